// File: rtl/llki_discrete_master.sv
// LLKI discrete master: accepts load/clear key commands and serializes the key MS word first to a discrete slave.
// Latency: a 2-word load with the slave always ready and complete delayed one cycle responds 5 cycles after accept.
// Backpressure: cmd_ready is high only in IDLE; key words are held stable until llkid_key_ready, and a stall of TIMEOUT cycles aborts.
module llki_discrete_master #(
  parameter int KEY_WORDS = 2,
  parameter int WORD_W    = 64,
  parameter int TIMEOUT   = 1023
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [KEY_WORDS*WORD_W-1:0] key_in,
  output logic                        rsp_valid,
  output logic [1:0]                  rsp_status,
  output logic                        busy,
  output logic [WORD_W-1:0]           llkid_key_data,
  output logic                        llkid_key_valid,
  input  logic                        llkid_key_ready,
  input  logic                        llkid_key_complete,
  output logic                        llkid_clear_key,
  input  logic                        llkid_clear_key_ack
);

  localparam int IDX_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ILLEGAL = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_CMPL,
    S_CLEAR,
    S_RESP
  } state_t;

  state_t                                 state_q, state_d;
  logic [IDX_W-1:0]                       idx_q, idx_d;
  logic [CNT_W-1:0]                       cnt_q, cnt_d;
  logic [KEY_WORDS-1:0][WORD_W-1:0]       shadow_q, shadow_d;
  logic [1:0]                             status_q, status_d;
  logic                                   timeout_hit;
  logic [IDX_W-1:0]                       word_sel;

  // The abort fires on the cycle the counter would step onto TIMEOUT, so a
  // silent slave sees exactly TIMEOUT cycles of request before it drops.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Word 0 is the most-significant slice of the shadow register.
  assign word_sel = IDX_W'(KEY_WORDS - 1) - idx_q;

  // State and datapath registers; reset aborts any operation silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      status_q <= status_d;
    end
  end

  // Next-state logic: handshakes and acknowledgements win over a same-cycle timeout.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cnt_d = '0;
          idx_d = '0;
          if (cmd_op == OP_LOAD) begin
            shadow_d = key_in;
            state_d  = S_LOAD;
          end else if (cmd_op == OP_CLEAR) begin
            shadow_d = key_in;
            state_d  = S_CLEAR;
          end else begin
            status_d = ST_ILLEGAL;
            state_d  = S_RESP;
          end
        end
      end
      S_LOAD: begin
        if (llkid_key_ready) begin
          cnt_d = '0;
          if (idx_q == IDX_W'(KEY_WORDS - 1)) begin
            idx_d   = '0;
            state_d = S_WAIT_CMPL;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (timeout_hit) begin
          idx_d    = '0;
          status_d = ST_TIMEOUT;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_CMPL: begin
        if (llkid_key_complete) begin
          status_d = ST_OK;
          state_d  = S_RESP;
        end else if (timeout_hit) begin
          status_d = ST_TIMEOUT;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CLEAR: begin
        if (llkid_clear_key_ack) begin
          status_d = ST_OK;
          state_d  = S_RESP;
        end else if (timeout_hit) begin
          status_d = ST_TIMEOUT;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        shadow_d = '0;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs; cmd_ready is also held low while reset is applied.
  always_comb begin
    cmd_ready       = (state_q == S_IDLE) && !rst;
    busy            = (state_q != S_IDLE);
    rsp_valid       = (state_q == S_RESP);
    rsp_status      = (state_q == S_RESP) ? status_q : 2'b00;
    llkid_key_valid = (state_q == S_LOAD);
    llkid_key_data  = (state_q == S_LOAD) ? shadow_q[word_sel] : '0;
    llkid_clear_key = (state_q == S_CLEAR);
  end

endmodule

// File: tb/tb_llki_discrete_master.sv
// Randomized bench for llki_discrete_master against a per-cycle schedule model.
// Each operation is expanded from its stall/delay parameters into expected outputs.
// Slave inputs follow the schedule; ignored inputs carry random noise.
module tb_llki_discrete_master;

  localparam int KW    = 2;
  localparam int WW    = 64;
  localparam int TO    = 8;
  localparam int KEY_W = KW * WW;
  localparam int MAXC  = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [KEY_W-1:0] key_in;
  logic             rsp_valid;
  logic [1:0]       rsp_status;
  logic             busy;
  logic [WW-1:0]    llkid_key_data;
  logic             llkid_key_valid;
  logic             llkid_key_ready;
  logic             llkid_key_complete;
  logic             llkid_clear_key;
  logic             llkid_clear_key_ack;

  always #5 clk = ~clk;

  llki_discrete_master #(.KEY_WORDS(KW), .WORD_W(WW), .TIMEOUT(TO)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_op              (cmd_op),
    .key_in              (key_in),
    .rsp_valid           (rsp_valid),
    .rsp_status          (rsp_status),
    .busy                (busy),
    .llkid_key_data      (llkid_key_data),
    .llkid_key_valid     (llkid_key_valid),
    .llkid_key_ready     (llkid_key_ready),
    .llkid_key_complete  (llkid_key_complete),
    .llkid_clear_key     (llkid_clear_key),
    .llkid_clear_key_ack (llkid_clear_key_ack)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected schedule, indexed by cycle offset from the accept cycle (0).
  int          stall [KW];
  logic        e_vld [MAXC];
  logic [WW-1:0] e_dat [MAXC];
  logic        e_clr [MAXC];
  logic        d_rdy [MAXC];
  logic        d_cmp [MAXC];
  logic        d_ack [MAXC];
  int          rsp_at;
  logic [1:0]  e_st;

  // Expand one operation into its cycle-by-cycle expectation.
  task automatic build_sched(input logic [1:0] op, input logic [KEY_W-1:0] key, input int dly);
    int  c;
    bit  to;
    for (int i = 0; i < MAXC; i++) begin
      e_vld[i] = 1'b0;
      e_dat[i] = '0;
      e_clr[i] = 1'b0;
      d_rdy[i] = 1'($urandom_range(0, 1));
      d_cmp[i] = 1'($urandom_range(0, 1));
      d_ack[i] = 1'($urandom_range(0, 1));
    end
    c  = 1;
    to = 1'b0;
    if (op == 2'b01) begin
      for (int i = 0; i < KW && !to; i++) begin
        for (int k = 0; k <= stall[i]; k++) begin
          if (k == TO) begin
            to = 1'b1;
            break;
          end
          e_vld[c] = 1'b1;
          e_dat[c] = WW'(key >> ((KW - 1 - i) * WW));
          d_rdy[c] = (k == stall[i]);
          c++;
        end
      end
      if (!to) begin
        for (int k = 0; k <= dly; k++) begin
          if (k == TO) begin
            to = 1'b1;
            break;
          end
          d_cmp[c] = (k == dly);
          c++;
        end
      end
      e_st = to ? 2'b01 : 2'b00;
    end else if (op == 2'b10) begin
      for (int k = 0; k <= dly; k++) begin
        if (k == TO) begin
          to = 1'b1;
          break;
        end
        e_clr[c] = 1'b1;
        d_ack[c] = (k == dly);
        c++;
      end
      e_st = to ? 2'b01 : 2'b00;
    end else begin
      e_st = 2'b10;
    end
    rsp_at = c;
  endtask

  // Drive one operation and compare every output each cycle.
  task automatic run_op(input logic [1:0] op, input logic [KEY_W-1:0] key, input int dly);
    build_sched(op, key, dly);
    for (int c = 0; c <= rsp_at + 1; c++) begin
      @(negedge clk);
      cmd_valid           = (c == 0) || (c == rsp_at);
      cmd_op              = (c == 0) ? op : 2'b01;
      key_in              = (c == 0) ? key : ~key;
      llkid_key_ready     = d_rdy[c];
      llkid_key_complete  = d_cmp[c];
      llkid_clear_key_ack = d_ack[c];
      #1;
      chk("cmd_ready", 128'(cmd_ready), 128'((c == 0) || (c == rsp_at + 1)));
      chk("busy", 128'(busy), 128'((c >= 1) && (c <= rsp_at)));
      chk("key_valid", 128'(llkid_key_valid), 128'(e_vld[c]));
      chk("key_data", 128'(llkid_key_data), 128'(e_dat[c]));
      chk("clear_key", 128'(llkid_clear_key), 128'(e_clr[c]));
      chk("rsp_valid", 128'(rsp_valid), 128'(c == rsp_at));
      chk("rsp_status", 128'(rsp_status), 128'((c == rsp_at) ? e_st : 2'b00));
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, 128'(cmd_ready), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
    chk({tag, "_rsp_status"}, 128'(rsp_status), 128'(0));
    chk({tag, "_key_valid"}, 128'(llkid_key_valid), 128'(0));
    chk({tag, "_key_data"}, 128'(llkid_key_data), 128'(0));
    chk({tag, "_clear_key"}, 128'(llkid_clear_key), 128'(0));
  endtask

  function automatic logic [KEY_W-1:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int rand_delay();
    int p;
    p = int'($urandom_range(0, 9));
    if (p < 7) return int'($urandom_range(0, 3));
    return TO - 1 + (p - 7);
  endfunction

  initial begin
    logic [KEY_W-1:0] k;
    logic [1:0]       op;
    int               p;
    rst                 = 1'b1;
    cmd_valid           = 1'b0;
    cmd_op              = 2'b00;
    key_in              = '0;
    llkid_key_ready     = 1'b0;
    llkid_key_complete  = 1'b0;
    llkid_clear_key_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_cmd_ready", 128'(cmd_ready), 128'(1));

    // Directed cases: nominal load, stalled load, clear, timeout + recovery, illegal ops.
    k = 128'h0123456789ABCDEF_FEDCBA9876543210;
    stall[0] = 0; stall[1] = 0;
    run_op(2'b01, k, 1);
    stall[0] = 3; stall[1] = 0;
    run_op(2'b01, k, 1);
    run_op(2'b10, k, 4);
    stall[0] = TO + 2; stall[1] = 0;
    run_op(2'b01, rand_key(), 1);
    stall[0] = 0; stall[1] = 0;
    run_op(2'b01, k, 1);
    stall[0] = 0; stall[1] = TO - 1;
    run_op(2'b01, rand_key(), TO - 1);
    run_op(2'b11, rand_key(), 0);
    run_op(2'b00, rand_key(), 0);

    // Reset in the middle of a load aborts without a response.
    @(negedge clk);
    cmd_valid       = 1'b1;
    cmd_op          = 2'b01;
    key_in          = rand_key();
    llkid_key_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("rst_pre_valid", 128'(llkid_key_valid), 128'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk_all_zero("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_post_ready", 128'(cmd_ready), 128'(1));
    chk("rst_post_rsp", 128'(rsp_valid), 128'(0));
    chk("rst_post_busy", 128'(busy), 128'(0));
    stall[0] = 1; stall[1] = 2;
    run_op(2'b01, rand_key(), 2);

    // Randomized mix of operations.
    for (int n = 0; n < 60; n++) begin
      p = int'($urandom_range(0, 7));
      if (p < 4)      op = 2'b01;
      else if (p < 6) op = 2'b10;
      else            op = (p == 6) ? 2'b00 : 2'b11;
      for (int i = 0; i < KW; i++) stall[i] = rand_delay();
      run_op(op, rand_key(), rand_delay());
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/llki_discrete_master.md
Name: llki_discrete_master

Overview:
- Initiator side of the LLKI discrete key-load interface.
- Accepts load-key and clear-key commands from an upstream key-delivery agent (SRoT-facing logic).
- Serializes the key into WORD_W-bit words toward an LLKI discrete slave inside a protected core (e.g. RSA, AES), then reports completion status upstream.
- Used in unit benches and in the tile-level LLKI glue to drive any core whose wrapper instantiates the discrete slave.

Parameters:
- KEY_WORDS, 2, number of WORD_W-bit words per key (2 gives a 128-bit key).
- WORD_W, 64, width of one key word on the discrete interface.
- TIMEOUT, 1023, cycles without slave progress before an operation aborts.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- cmd_valid  input  1  upstream command valid.
- cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high.
- cmd_op  input  2  01 = load key, 10 = clear key; 00 and 11 are illegal.
- key_in  input  KEY_WORDS*WORD_W  key value, sampled only on command accept.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_status  output  2  00 = ok, 01 = timeout, 10 = illegal op; valid only while rsp_valid is high.
- busy  output  1  high in every state except IDLE.
- llkid_key_data  output  WORD_W  current key word; forced to 0 whenever llkid_key_valid is low.
- llkid_key_valid  output  1  key word valid.
- llkid_key_ready  input  1  slave accepts the current word.
- llkid_key_complete  input  1  slave reports the full key is loaded.
- llkid_clear_key  output  1  clear request to the slave.
- llkid_clear_key_ack  input  1  slave acknowledges the clear.

Behaviour:
- Reset: all outputs 0, FSM goes to IDLE, word index = 0, timeout counter = 0, key shadow register zeroed.
- Reset asserted mid-operation aborts immediately and generates no response.
- FSM states: IDLE, LOAD, WAIT_CMPL, CLEAR, RESP.
- IDLE:
  - Accept at edge T.
  - Legal op: key_in is latched into the shadow register; next state is LOAD (op 01) or CLEAR (op 10).
  - Illegal op: next state RESP with status 10; no downstream activity.
- LOAD:
  - llkid_key_valid is high from cycle T+1.
  - Word i = shadow[(KEY_WORDS-i)*WORD_W-1 -: WORD_W], so the most-significant word goes first.
  - Data and valid are held stable until llkid_key_ready is sampled high.
  - On a handshake of word i < KEY_WORDS-1: index increments, valid stays high, word i+1 is driven the next cycle. Back-to-back words with ready held high take 1 cycle each.
  - On the last-word handshake: valid drops the next cycle, index resets to 0, next state WAIT_CMPL.
  - llkid_key_complete is ignored in LOAD.
- WAIT_CMPL: llkid_key_complete sampled high leads to RESP with status 00.
- CLEAR: llkid_clear_key is high from T+1 until llkid_clear_key_ack is sampled high; clear then drops the next cycle and the FSM goes to RESP with status 00.
- RESP:
  - rsp_valid is high for exactly one cycle with rsp_status.
  - The shadow register is zeroed in this cycle.
  - Next state IDLE; cmd_ready returns high the following cycle. No back-to-back accept in the RESP cycle.
- Timeout:
  - The counter clears on entry to LOAD, WAIT_CMPL or CLEAR, and on every word handshake.
  - It increments each cycle in those states.
  - When it reaches TIMEOUT, llkid_key_valid and llkid_clear_key drop the next cycle, index resets, and the FSM goes to RESP with status 01.
  - A handshake in the same cycle the counter reaches TIMEOUT takes priority: the counter clears and no timeout occurs.
- cmd_valid is ignored while busy; cmd_ready is 0.
- Latency: a 2-word load with the slave always ready and complete asserted one cycle after the last word gives rsp_valid at T+5.

Test Plan:
- Reset, then load op=01, key_in=128'h0123456789ABCDEF_FEDCBA9876543210, ready tied 1, complete pulses 1 cycle after the last word -> data 64'h0123456789ABCDEF then 64'hFEDCBA9876543210 on consecutive cycles, rsp_valid at T+5 with status 00.
- Same load with ready stalled 3 cycles on word 0 -> data and valid held stable during the stall; all words delivered in order; status 00.
- Clear op=10 with ack after 4 cycles -> llkid_clear_key high for 5 cycles, then rsp status 00; llkid_key_valid never asserts.
- Load with TIMEOUT=8 and ready tied 0 -> valid drops after 8 cycles, rsp status 01, index back to 0; a following load succeeds.
- cmd_op=11 -> rsp status 10 at T+1, no downstream signal toggles; rst asserted during LOAD -> all outputs 0 next edge, no rsp_valid.
